// File: rtl/bcd_add_pkg.sv
// Shared definitions for the BCD adder control path and datapath.
// Holds the op index encoding, the controller state encoding and the op
// sequencing helper.
package bcd_add_pkg;

  localparam int unsigned NUM_OPS = 7;
  localparam int unsigned OP_W    = 3;

  // Op index encoding; also the bit position of each request/ack line
  localparam logic [OP_W-1:0] OP_INIT    = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD_A  = 3'd1;
  localparam logic [OP_W-1:0] OP_DISP_A  = 3'd2;
  localparam logic [OP_W-1:0] OP_LOAD_B  = 3'd3;
  localparam logic [OP_W-1:0] OP_DISP_B  = 3'd4;
  localparam logic [OP_W-1:0] OP_DISP_LS = 3'd5;
  localparam logic [OP_W-1:0] OP_DISP_MS = 3'd6;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_REL  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } ctrl_state_t;

  // INIT is never revisited: after the last display the sequence wraps to LOAD_A
  function automatic logic [OP_W-1:0] next_op(input logic [OP_W-1:0] op);
    return (op == OP_DISP_MS) ? OP_LOAD_A : OP_W'(op + 3'd1);
  endfunction

endpackage

// File: rtl/bcd_add_controller_hs_watchdog.sv
// Handshake watchdog: counts cycles spent in one handshake phase.
// Ports: clock, reset (sync, active-high), clr (restart count), en (count this
// cycle), timeout_c (combinational: this is the ACK_TIMEOUT-th waiting cycle).
// ACK_TIMEOUT = 0 disables the timeout.
module hs_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TW          = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout_c
);

  // cnt holds the number of waiting cycles already completed in this phase
  localparam logic [TW-1:0] LAST = (ACK_TIMEOUT == 0) ? '0 : TW'(ACK_TIMEOUT - 1);
  localparam logic          ENABLED = (ACK_TIMEOUT != 0);

  logic [TW-1:0] cnt;

  // Saturating cycle counter
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign timeout_c = ENABLED && en && (cnt == LAST);

endmodule

// File: rtl/bcd_add_controller.sv
// Control-path initiator for bcd_add_datapath. Runs one four-phase req/ack
// handshake per op, INIT once after reset, then one op per step pulse.
// Ports: clock, reset (sync, active-high), step, seven *_ack inputs from the
// datapath, seven request outputs, phase (current op), busy, op_done (pulse),
// error (sticky until reset). All outputs are registered.
module bcd_add_controller
  import bcd_add_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TW          = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            step,
  input  logic            init_ack,
  input  logic            load_a_ack,
  input  logic            load_b_ack,
  input  logic            display_a_ack,
  input  logic            display_b_ack,
  input  logic            display_ls_ack,
  input  logic            display_ms_ack,
  output logic            init,
  output logic            load_a,
  output logic            load_b,
  output logic            display_a,
  output logic            display_b,
  output logic            display_ls,
  output logic            display_ms,
  output logic [OP_W-1:0] phase,
  output logic            busy,
  output logic            op_done,
  output logic            error
);

  ctrl_state_t          state, state_nxt;
  logic [OP_W-1:0]      op_idx, op_nxt;
  logic [NUM_OPS-1:0]   ack_vec, op_mask;
  logic                 cur_ack, other_ack;
  logic                 rel_exit;
  logic                 timeout_c;

  logic [NUM_OPS-1:0]   req_c, req_q;
  logic                 busy_c, busy_q, error_c, error_q;
  logic                 done_pend, op_done_q;
  logic [OP_W-1:0]      phase_q;

  // Ack lines packed in op-index order
  assign ack_vec = {display_ms_ack, display_ls_ack, display_b_ack, load_b_ack,
                    display_a_ack, load_a_ack, init_ack};
  assign op_mask   = NUM_OPS'(1) << op_idx;
  assign cur_ack   = |(ack_vec & op_mask);
  assign other_ack = |(ack_vec & ~op_mask);

  hs_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .TW          (TW)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clr       (state_nxt != state),
    .en        ((state == ST_REQ) || (state == ST_REL)),
    .timeout_c (timeout_c)
  );

  // State and op index register
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_REQ;
      op_idx <= OP_INIT;
    end else begin
      state  <= state_nxt;
      op_idx <= op_nxt;
    end
  end

  // Next state, op advance and Moore output decode
  always_comb begin
    state_nxt = state;
    op_nxt    = op_idx;
    rel_exit  = 1'b0;
    req_c     = '0;
    busy_c    = 1'b0;
    error_c   = 1'b0;
    case (state)
      ST_REQ: begin
        req_c  = op_mask;
        busy_c = 1'b1;
        if (timeout_c || other_ack) begin
          state_nxt = ST_ERR;
        end else if (cur_ack) begin
          state_nxt = ST_REL;
        end
      end
      ST_REL: begin
        busy_c = 1'b1;
        if (timeout_c || other_ack) begin
          state_nxt = ST_ERR;
        end else if (!cur_ack) begin
          state_nxt = ST_WAIT;
          rel_exit  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (step) begin
          state_nxt = ST_REQ;
          op_nxt    = next_op(op_idx);
        end
      end
      ST_ERR: begin
        error_c = 1'b1;
      end
      default: begin
        state_nxt = ST_ERR;
      end
    endcase
  end

  // Output registers; op_done trails the REL exit by one extra cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q     <= '0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      phase_q   <= OP_INIT;
      done_pend <= 1'b0;
      op_done_q <= 1'b0;
    end else begin
      req_q     <= req_c;
      busy_q    <= busy_c;
      error_q   <= error_c;
      phase_q   <= op_idx;
      done_pend <= rel_exit;
      op_done_q <= done_pend;
    end
  end

  assign init       = req_q[OP_INIT];
  assign load_a     = req_q[OP_LOAD_A];
  assign display_a  = req_q[OP_DISP_A];
  assign load_b     = req_q[OP_LOAD_B];
  assign display_b  = req_q[OP_DISP_B];
  assign display_ls = req_q[OP_DISP_LS];
  assign display_ms = req_q[OP_DISP_MS];
  assign phase      = phase_q;
  assign busy       = busy_q;
  assign op_done    = op_done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_bcd_add_controller.sv
// Directed bench for bcd_add_controller: datapath ack responder, op_done
// scoreboard of expected phases, one-hot request monitor.
module tb_bcd_add_controller;

  localparam int unsigned ACK_TIMEOUT = 16;

  logic       clock;
  logic       reset;
  logic       step;
  logic [6:0] ack_v;
  logic [6:0] stray_v;
  logic [6:0] ack_in;
  logic [6:0] req_v;
  logic       init, load_a, load_b, display_a, display_b, display_ls, display_ms;
  logic [2:0] phase;
  logic       busy, op_done, error;

  assign ack_in = ack_v | stray_v;
  assign req_v  = {display_ms, display_ls, display_b, load_b, display_a, load_a, init};

  bcd_add_controller #(.ACK_TIMEOUT(ACK_TIMEOUT), .TW(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .step           (step),
    .init_ack       (ack_in[0]),
    .load_a_ack     (ack_in[1]),
    .load_b_ack     (ack_in[3]),
    .display_a_ack  (ack_in[2]),
    .display_b_ack  (ack_in[4]),
    .display_ls_ack (ack_in[5]),
    .display_ms_ack (ack_in[6]),
    .init           (init),
    .load_a         (load_a),
    .load_b         (load_b),
    .display_a      (display_a),
    .display_b      (display_b),
    .display_ls     (display_ls),
    .display_ms     (display_ms),
    .phase          (phase),
    .busy           (busy),
    .op_done        (op_done),
    .error          (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         rise_cnt [7];
  logic [6:0] req_prev = '0;
  logic [2:0] exp_q [$];
  logic [2:0] exp_phase = 3'd0;
  logic       resp_en = 1'b1;
  logic       ack_hold = 1'b0;
  int         ack_delay = 1;
  int         dly = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, run monitor, scoreboard and ack responder
  task automatic tick();
    logic [2:0] e;
    @(negedge clock);
    chk("req_onehot", 32'($countones(req_v) <= 1), 1);
    for (int i = 0; i < 7; i++) begin
      if (req_v[i] && !req_prev[i]) rise_cnt[i]++;
    end
    req_prev = req_v;
    if (op_done === 1'b1) begin
      done_cnt++;
      chk("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("op_done_phase", 32'(phase), 32'(e));
      end
    end
    for (int i = 0; i < 7; i++) begin
      if (resp_en && req_v[i] && !ack_v[i]) begin
        if (dly >= ack_delay) ack_v[i] = 1'b1;
        else dly++;
      end else if (!req_v[i] && ack_v[i] && !ack_hold) begin
        ack_v[i] = 1'b0;
        dly = 0;
      end
    end
  endtask

  task automatic do_step(input logic expect_done);
    exp_phase = (exp_phase == 3'd6) ? 3'd1 : 3'(exp_phase + 3'd1);
    if (expect_done) exp_q.push_back(exp_phase);
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic pulse_step_ignored();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int start;
    start = done_cnt;
    for (int c = 0; c < 60 && done_cnt == start; c++) tick();
    chk(tag, 32'(done_cnt - start), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    resp_en = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    exp_phase = 3'd0;
    exp_q.push_back(3'd0);
    for (int i = 0; i < 7; i++) rise_cnt[i] = 0;
    reset = 1'b0;
    wait_done("init_rerun");
    chk("reset_error_clear", 32'(error), 0);
    chk("reset_phase", 32'(phase), 0);
    chk("init_once", 32'(rise_cnt[0]), 1);
  endtask

  initial begin
    int hi;
    int found;
    reset   = 1'b1;
    step    = 1'b0;
    ack_v   = '0;
    stray_v = '0;
    for (int i = 0; i < 7; i++) rise_cnt[i] = 0;
    repeat (3) tick();

    // Reset values
    chk("rst_req", 32'(req_v), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_done", 32'(op_done), 0);
    chk("rst_error", 32'(error), 0);

    // Automatic INIT after reset release
    exp_q.push_back(3'd0);
    reset = 1'b0;
    tick();
    chk("init_after_reset", 32'(init), 1);
    wait_done("init_done");
    chk("init_phase", 32'(phase), 0);

    // Six steps walk the full op sequence
    for (int k = 1; k <= 6; k++) begin
      do_step(1'b1);
      wait_done("seq_done");
    end
    chk("seq_phase", 32'(phase), 6);
    for (int i = 0; i < 7; i++) chk("seq_req_once", 32'(rise_cnt[i]), 1);

    // Seventh step wraps to LOAD_A without INIT
    do_step(1'b1);
    wait_done("wrap_done");
    chk("wrap_phase", 32'(phase), 1);
    chk("wrap_no_init", 32'(rise_cnt[0]), 1);
    chk("wrap_load_a", 32'(rise_cnt[1]), 2);

    // Steps during REQ and REL are dropped
    ack_delay = 5;
    ack_hold  = 1'b1;
    do_step(1'b1);
    repeat (2) tick();
    chk("req_busy", 32'(busy), 1);
    pulse_step_ignored();
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      if (!display_a && ack_in[2]) found = 1;
    end
    chk("rel_reached", 32'(found), 1);
    pulse_step_ignored();
    repeat (2) tick();
    ack_hold = 1'b0;
    wait_done("ign_done");
    repeat (3) tick();
    chk("ign_phase", 32'(phase), 2);
    chk("ign_busy", 32'(busy), 0);
    chk("ign_disp_a", 32'(rise_cnt[2]), 2);
    ack_delay = 1;

    // Foreign ack during LOAD_B request
    resp_en = 1'b0;
    do_step(1'b0);
    tick();
    chk("load_b_req", 32'(load_b), 1);
    stray_v[2] = 1'b1;
    tick();
    stray_v = '0;
    tick();
    chk("viol_error", 32'(error), 1);
    chk("viol_load_b", 32'(load_b), 0);
    chk("viol_phase", 32'(phase), 3);
    pulse_step_ignored();
    stray_v[3] = 1'b1;
    repeat (2) tick();
    stray_v = '0;
    chk("viol_sticky", 32'(error), 1);
    chk("viol_req", 32'(req_v), 0);
    chk("viol_phase_hold", 32'(phase), 3);
    do_reset();

    // Watchdog: LOAD_A never acknowledged
    resp_en = 1'b0;
    do_step(1'b0);
    hi = 0;
    for (int c = 0; c < 40 && error !== 1'b1; c++) begin
      tick();
      if (load_a) hi++;
    end
    chk("to_error", 32'(error), 1);
    chk("to_req_cycles", 32'(hi), ACK_TIMEOUT);
    chk("to_load_a", 32'(load_a), 0);
    pulse_step_ignored();
    stray_v[1] = 1'b1;
    repeat (2) tick();
    stray_v = '0;
    chk("to_sticky", 32'(error), 1);
    chk("to_phase", 32'(phase), 1);
    chk("to_req", 32'(req_v), 0);
    do_reset();

    // Reset in REL of DISP_LS while its ack is still high
    for (int k = 1; k <= 4; k++) begin
      do_step(1'b1);
      wait_done("pre_ls_done");
    end
    ack_hold = 1'b1;
    do_step(1'b1);
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      if (!display_ls && ack_in[5]) found = 1;
    end
    chk("ls_rel_reached", 32'(found), 1);
    chk("ls_phase", 32'(phase), 5);
    reset = 1'b1;
    tick();
    chk("mid_rst_phase", 32'(phase), 0);
    chk("mid_rst_req", 32'(req_v), 0);
    chk("mid_rst_error", 32'(error), 0);
    ack_hold = 1'b0;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no end expected end");
    $fatal(1, "bench time limit");
  end

endmodule
